mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving an external 4:1 mux: grants one requester, waits one
// cycle for the mux to settle, captures its output and holds it until accepted.
//
// state | meaning
// IDLE  | no transfer; evaluate req and grant the next channel in rotation
// SEL   | sel/gnt driven, mux settling; capture mux_out on exit
// SEND  | out_data valid, waiting for out_ready
module mux_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;

  state_t     state, state_next;
  logic [1:0] last;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       win_found;

  // Scan upward from the channel after the last one served, wrapping at 3.
  always_comb begin
    win_idx   = last;
    win_found = 1'b0;
    cand      = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = SEL;
      SEL:     state_next = SEND;
      SEND:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 2'd0;
      gnt       <= 4'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= 8'd0;
      last      <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            sel <= win_idx;
            gnt <= 4'b0001 << win_idx;
          end
        end
        SEL: begin
          out_data  <= mux_out;
          out_valid <= 1'b1;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            gnt       <= 4'd0;
            last      <= sel;
            xfer_cnt  <= xfer_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table for the rotation/latency behaviour
// plus hand-written sequences for back-pressure, async reset and counter wrap.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mux_out;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] xfer_cnt;
  logic [3:0] noise;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mux_out  (mux_out),
    .sel      (sel),
    .gnt      (gnt),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  // Mux model: channel a..d carry 0..3, optionally disturbed by noise.
  assign mux_out = 4'(sel) + noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] data;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    out_ready = 1'b0;
    noise = 4'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_gnt,
                           input logic e_valid, input logic [3:0] e_data, input logic [7:0] e_cnt);
    check({tag, ".sel"},   32'(sel),       32'(e_sel));
    check({tag, ".gnt"},   32'(gnt),       32'(e_gnt));
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".data"},  32'(out_data),  32'(e_data));
    check({tag, ".cnt"},   32'(xfer_cnt),  32'(e_cnt));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'd0;
    out_ready = 1'b0;
    noise = 4'd0;

    //              rst req      rdy  sel gnt      v  data cnt
    vecs.push_back('{1, 4'b0000, 0,   0, 4'b0000, 0, 0, 0});
    vecs.push_back('{0, 4'b0100, 1,   2, 4'b0100, 0, 0, 0});
    vecs.push_back('{0, 4'b0100, 1,   2, 4'b0100, 1, 2, 0});
    vecs.push_back('{0, 4'b0000, 1,   2, 4'b0000, 0, 2, 1});
    vecs.push_back('{0, 4'b0000, 1,   2, 4'b0000, 0, 2, 1});
    vecs.push_back('{1, 4'b0000, 0,   0, 4'b0000, 0, 0, 0});
    vecs.push_back('{0, 4'b1111, 1,   0, 4'b0001, 0, 0, 0});
    vecs.push_back('{0, 4'b1111, 1,   0, 4'b0001, 1, 0, 0});
    vecs.push_back('{0, 4'b1111, 1,   0, 4'b0000, 0, 0, 1});
    vecs.push_back('{0, 4'b1111, 1,   1, 4'b0010, 0, 0, 1});
    vecs.push_back('{0, 4'b1111, 1,   1, 4'b0010, 1, 1, 1});
    vecs.push_back('{0, 4'b1111, 1,   1, 4'b0000, 0, 1, 2});
    vecs.push_back('{0, 4'b1111, 1,   2, 4'b0100, 0, 1, 2});
    vecs.push_back('{0, 4'b1111, 1,   2, 4'b0100, 1, 2, 2});
    vecs.push_back('{0, 4'b1111, 1,   2, 4'b0000, 0, 2, 3});
    vecs.push_back('{0, 4'b1111, 1,   3, 4'b1000, 0, 2, 3});
    vecs.push_back('{0, 4'b1111, 1,   3, 4'b1000, 1, 3, 3});
    vecs.push_back('{0, 4'b1111, 1,   3, 4'b0000, 0, 3, 4});
    vecs.push_back('{0, 4'b1111, 1,   0, 4'b0001, 0, 3, 4});
    vecs.push_back('{0, 4'b0000, 1,   0, 4'b0001, 1, 0, 4});
    vecs.push_back('{0, 4'b1010, 1,   0, 4'b0000, 0, 0, 5});
    vecs.push_back('{0, 4'b1010, 0,   1, 4'b0010, 0, 0, 5});
    vecs.push_back('{0, 4'b0000, 0,   1, 4'b0010, 1, 1, 5});
    vecs.push_back('{0, 4'b0101, 0,   1, 4'b0010, 1, 1, 5});
    vecs.push_back('{0, 4'b0101, 1,   1, 4'b0000, 0, 1, 6});
    vecs.push_back('{0, 4'b0101, 0,   2, 4'b0100, 0, 1, 6});

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      out_ready = vecs[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].gnt, vecs[i].valid,
                vecs[i].data, vecs[i].cnt);
    end

    // Back-pressure: grant channel 1, hold 10 cycles with mux_out and req moving.
    do_reset();
    req = 4'b0010;
    step();
    check_all("bp.grant", 1, 4'b0010, 0, 0, 0);
    step();
    check_all("bp.capture", 1, 4'b0010, 1, 1, 0);
    for (int c = 0; c < 10; c++) begin
      noise = 4'(c + 5);
      req = 4'b1101;
      step();
      check_all($sformatf("bp.hold%0d", c), 1, 4'b0010, 1, 1, 0);
    end
    noise = 4'd0;
    out_ready = 1'b1;
    step();
    check_all("bp.accept", 1, 4'b0000, 0, 1, 1);
    req = 4'd0;
    out_ready = 1'b0;
    step();
    check_all("bp.idle", 1, 4'b0000, 0, 1, 1);

    // Async reset mid-SEND: outputs clear before the next edge, transfer not counted.
    req = 4'b0100;
    step();
    check_all("ar.grant", 2, 4'b0100, 0, 1, 1);
    step();
    check_all("ar.send", 2, 4'b0100, 1, 2, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all("ar.async", 0, 4'b0000, 0, 0, 0);
    #1;
    rst = 1'b0;
    req = 4'b1010;
    out_ready = 1'b1;
    step();
    check_all("ar.regrant", 1, 4'b0010, 0, 0, 0);
    step();
    check_all("ar.capture", 1, 4'b0010, 1, 1, 0);
    step();
    check_all("ar.done", 1, 4'b0000, 0, 1, 1);

    // Counter wrap after 256 transfers.
    do_reset();
    req = 4'b0001;
    out_ready = 1'b1;
    repeat (255 * 3) step();
    check("wrap.cnt255", 32'(xfer_cnt), 32'd255);
    repeat (3) step();
    check("wrap.cnt0", 32'(xfer_cnt), 32'd0);
    check("wrap.valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
